// File: rtl/branch_stall_ctrl.sv
// Hazard-stall controller for the 5-stage pipeline: freezes PC and IF/ID and bubbles ID/EX
// for hazards forwarding cannot cover, flushes IF/ID on a taken beq, and keeps saturating statistics.
//
// state | meaning
// RUN   | normal issue; hazards are evaluated and may stall combinationally this cycle
// HOLD  | extra stall cycle of a lw->beq hazard; hazard inputs ignored, rem counts down
module branch_stall_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_Ra,
   input  logic [4:0]       id_Rb,
   input  logic             id_UseRb,
   input  logic             id_Branch,
   input  logic             id_Zero,
   input  logic [4:0]       ex_Rw,
   input  logic             ex_RegWr,
   input  logic             ex_MemtoReg,
   input  logic [4:0]       mem_Rw,
   input  logic             mem_RegWr,
   input  logic             mem_MemtoReg,
   output logic             PCWr,
   output logic             IFIDWr,
   output logic             IDEXBubble,
   output logic             IFIDFlush,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } stateT;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stateT      state;
   stateT      stateNext;
   logic       rem;
   logic       remNext;
   logic       exMatch;
   logic       memMatch;
   logic [1:0] need;
   logic       stallRaw;
   logic       flushRaw;
   logic       stallAct;
   logic       flushAct;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   always_comb begin
      exMatch  = ex_RegWr && (ex_Rw != 5'd0) &&
                 ((ex_Rw == id_Ra) || (id_UseRb && (ex_Rw == id_Rb)));
      memMatch = mem_RegWr && (mem_Rw != 5'd0) &&
                 ((mem_Rw == id_Ra) || (id_UseRb && (mem_Rw == id_Rb)));
   end

   // Cases overlap only as maxima, never as sums; a MEM ALU result is forwarded.
   always_comb begin
      need = 2'd0;
      if (id_Branch) begin
         if (exMatch) begin
            need = ex_MemtoReg ? 2'd2 : 2'd1;
         end else if (memMatch && mem_MemtoReg) begin
            need = 2'd1;
         end
      end else if (exMatch && ex_MemtoReg) begin
         need = 2'd1;
      end
   end

   always_comb begin
      stateNext = state;
      remNext   = rem;
      stallRaw  = 1'b0;
      flushRaw  = 1'b0;
      case (state)
         RUN: begin
            if (need != 2'd0) begin
               stallRaw = 1'b1;
               if (need == 2'd2) begin
                  stateNext = HOLD;
                  remNext   = 1'b1;
               end
            end else begin
               flushRaw = id_Branch && id_Zero;
            end
         end
         HOLD: begin
            stallRaw  = 1'b1;
            remNext   = rem - 1'b1;
            stateNext = (remNext == 1'b0) ? RUN : HOLD;
         end
         default: begin
            stateNext = RUN;
            remNext   = 1'b0;
         end
      endcase
   end

   // Reset must release the pipeline at once, even while a hazard is still presented.
   assign stallAct   = stallRaw && rst_n;
   assign flushAct   = flushRaw && rst_n;
   assign PCWr       = ~stallAct;
   assign IFIDWr     = ~stallAct;
   assign IDEXBubble = stallAct;
   assign IFIDFlush  = flushAct;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         rem   <= 1'b0;
      end else begin
         state <= stateNext;
         rem   <= remNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stallAct && (StallCnt != CNT_MAX)) begin
            StallCnt <= StallCnt + CNT_ONE;
         end
         if (flushAct && (FlushCnt != CNT_MAX)) begin
            FlushCnt <= FlushCnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Scoreboard bench for branch_stall_ctrl: directed hazard scenarios plus random traffic,
// checked against a remaining-stall-cycles model; a CNT_W=4 copy exercises counter saturation.
module tb_branch_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_Ra = '0, id_Rb = '0, ex_Rw = '0, mem_Rw = '0;
   logic       id_UseRb = 0, id_Branch = 0, id_Zero = 0;
   logic       ex_RegWr = 0, ex_MemtoReg = 0, mem_RegWr = 0, mem_MemtoReg = 0;

   logic        pcWr16, ifidWr16, bubble16, flush16;
   logic [15:0] stallCnt16, flushCnt16;
   logic        pcWr4, ifidWr4, bubble4, flush4;
   logic [3:0]  stallCnt4, flushCnt4;

   always #5 clk = ~clk;

   branch_stall_ctrl #(.CNT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .id_Ra(id_Ra), .id_Rb(id_Rb), .id_UseRb(id_UseRb),
      .id_Branch(id_Branch), .id_Zero(id_Zero), .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr),
      .ex_MemtoReg(ex_MemtoReg), .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr),
      .mem_MemtoReg(mem_MemtoReg), .PCWr(pcWr16), .IFIDWr(ifidWr16),
      .IDEXBubble(bubble16), .IFIDFlush(flush16), .StallCnt(stallCnt16), .FlushCnt(flushCnt16));

   branch_stall_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_Ra(id_Ra), .id_Rb(id_Rb), .id_UseRb(id_UseRb),
      .id_Branch(id_Branch), .id_Zero(id_Zero), .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr),
      .ex_MemtoReg(ex_MemtoReg), .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr),
      .mem_MemtoReg(mem_MemtoReg), .PCWr(pcWr4), .IFIDWr(ifidWr4),
      .IDEXBubble(bubble4), .IFIDFlush(flush4), .StallCnt(stallCnt4), .FlushCnt(flushCnt4));

   typedef struct {
      logic stall;
      logic flush;
      int   sCnt16;
      int   fCnt16;
      int   sCnt4;
      int   fCnt4;
   } expT;

   expT expQ[$];
   int  nChecks = 0;
   int  nPass = 0;

   // Reference model: stall cycles still owed, raw event totals, last cycle's decision.
   int  holdLeft = 0;
   int  nextHold = 0;
   int  sTotal = 0;
   int  fTotal = 0;
   bit  lastStall = 0;
   bit  lastFlush = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   function automatic bit writes(input logic wr, input logic [4:0] rw,
                                 input logic [4:0] ra, input logic [4:0] rb, input logic useRb);
      return wr && (rw != 0) && ((rw == ra) || (useRb && (rw == rb)));
   endfunction

   function automatic int needOf();
      int  n = 0;
      bit  exHit  = writes(ex_RegWr, ex_Rw, id_Ra, id_Rb, id_UseRb);
      bit  memHit = writes(mem_RegWr, mem_Rw, id_Ra, id_Rb, id_UseRb);
      if (id_Branch) begin
         if (exHit) n = ex_MemtoReg ? 2 : 1;
         if (memHit && mem_MemtoReg && n < 1) n = 1;
      end else if (exHit && ex_MemtoReg) begin
         n = 1;
      end
      return n;
   endfunction

   task automatic driveCycle(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                             input logic useRb, input logic br, input logic zero,
                             input logic [4:0] exRw, input logic exWr, input logic exMem,
                             input logic [4:0] memRw, input logic memWr, input logic memMem);
      expT e;
      int  n;
      @(posedge clk);
      if (rst_n) begin
         if (lastStall) sTotal++;
         if (lastFlush) fTotal++;
         holdLeft = nextHold;
      end
      #1;
      rst_n = r; id_Ra = ra; id_Rb = rb; id_UseRb = useRb; id_Branch = br; id_Zero = zero;
      ex_Rw = exRw; ex_RegWr = exWr; ex_MemtoReg = exMem;
      mem_Rw = memRw; mem_RegWr = memWr; mem_MemtoReg = memMem;
      if (!r) begin
         holdLeft = 0; sTotal = 0; fTotal = 0; nextHold = 0;
         e.stall = 0; e.flush = 0;
      end else if (holdLeft > 0) begin
         e.stall = 1; e.flush = 0; nextHold = holdLeft - 1;
      end else begin
         n = needOf();
         e.stall = (n > 0);
         e.flush = (n == 0) && br && zero;
         nextHold = (n > 0) ? n - 1 : 0;
      end
      e.sCnt16 = sat(sTotal, 65535); e.fCnt16 = sat(fTotal, 65535);
      e.sCnt4  = sat(sTotal, 15);    e.fCnt4  = sat(fTotal, 15);
      lastStall = e.stall;
      lastFlush = e.flush;
      expQ.push_back(e);
   endtask

   task automatic idle();
      driveCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      expT e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("PCWr",       int'(pcWr16),     int'(!e.stall));
            chk("IFIDWr",     int'(ifidWr16),   int'(!e.stall));
            chk("IDEXBubble", int'(bubble16),   int'(e.stall));
            chk("IFIDFlush",  int'(flush16),    int'(e.flush));
            chk("StallCnt",   int'(stallCnt16), e.sCnt16);
            chk("FlushCnt",   int'(flushCnt16), e.fCnt16);
            chk("StallCnt4",  int'(stallCnt4),  e.sCnt4);
            chk("FlushCnt4",  int'(flushCnt4),  e.fCnt4);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
      $fatal(1);
   end

   initial begin : stimulus
      // reset state
      driveCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      // lw $2 in EX, beq $2,$3: two stall cycles, then taken branch flushes
      driveCycle(1, 2, 3, 1, 1, 0, 2, 1, 1, 0, 0, 0);
      driveCycle(1, 2, 3, 1, 1, 0, 0, 0, 0, 2, 1, 1);
      driveCycle(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      idle();
      // add $4 in EX feeding beq $1,$4: one stall; then add in MEM is forwarded
      driveCycle(1, 1, 4, 1, 1, 0, 4, 1, 0, 0, 0, 0);
      driveCycle(1, 1, 4, 1, 1, 1, 0, 0, 0, 4, 1, 0);
      idle();
      driveCycle(1, 1, 4, 1, 1, 0, 0, 0, 0, 4, 1, 0);
      // load-use, then same with Rw = 0; rt match ignored when rt is not a source
      driveCycle(1, 5, 7, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      driveCycle(1, 5, 7, 1, 0, 0, 0, 1, 1, 0, 0, 0);
      driveCycle(1, 6, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      // beq with no hazard, taken and not taken
      driveCycle(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      driveCycle(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      // hazard plus taken branch: stall wins, no flush while stalling
      driveCycle(1, 3, 4, 1, 1, 1, 3, 1, 0, 0, 0, 0);
      driveCycle(1, 3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      // reset in the HOLD cycle of a lw/beq stall, hazard inputs kept
      driveCycle(1, 2, 3, 1, 1, 0, 2, 1, 1, 0, 0, 0);
      driveCycle(0, 2, 3, 1, 1, 0, 2, 1, 1, 0, 0, 0);
      driveCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      driveCycle(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      // sustained load-use: the 4-bit counter stops at 15
      for (int i = 0; i < 20; i++) driveCycle(1, 5, 7, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      idle();
      // random traffic over a small register range so matches are frequent
      for (int i = 0; i < 2000; i++) begin
         driveCycle(($urandom_range(0, 99) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end
      idle();
      repeat (3) @(negedge clk);
      chk("queue_drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
